arb_cycle_extract: RTL and testbench

- Sits directly downstream of the Bellman-Ford relaxation stage.
- Once relaxation completes, it scans every edge one more time to detect a negative-weight (arbitrage) cycle.
- On the first violating edge, it walks the predecessor chain in vertmat until it is guaranteed to be inside the cycle.
- It then streams the cycle's vertex indices out over a valid/ready handshake. Vertmat and adjmat access is read-only.

---
 rtl/arb_cycle_extract.sv | 183 ++++++++++++++++++
 tb/tb_arb_cycle_extract.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arb_cycle_extract.sv
// Negative-cycle (arbitrage) detector run after Bellman-Ford relaxation.
// Rescans every edge, walks predecessors into the cycle, then streams its vertices out.
module arb_cycle_extract #(
    parameter int unsigned         NODES    = 16,
    parameter int unsigned         PRED_W   = 8,
    parameter int unsigned         WEIGHT_W = 32,
    parameter logic [WEIGHT_W-1:0] INF      = {1'b0, {(WEIGHT_W-1){1'b1}}}
) (
    input  logic                       clk,
    input  logic                       cycle_reset,
    input  logic                       bellman_done,
    input  logic [PRED_W+WEIGHT_W-1:0] vertmat_q_a,
    input  logic [PRED_W+WEIGHT_W-1:0] vertmat_q_b,
    input  logic [WEIGHT_W-1:0]        adjmat_q,
    output logic [PRED_W-1:0]          vertmat_addr_a,
    output logic [PRED_W-1:0]          vertmat_addr_b,
    output logic [PRED_W-1:0]          adjmat_row_addr,
    output logic [PRED_W-1:0]          adjmat_col_addr,
    output logic [PRED_W-1:0]          out_vertex,
    output logic                       out_valid,
    output logic                       out_last,
    input  logic                       out_ready,
    output logic                       cycle_found,
    output logic [PRED_W:0]            cycle_len,
    output logic                       cycle_done
);

    typedef enum logic [2:0] {
        StIdle, StScanRd, StScanChk, StWalkRd, StWalk, StEmitRd, StEmit, StDone
    } state_e;

    localparam logic [PRED_W-1:0] LastIdx = PRED_W'(NODES - 1);
    localparam logic [PRED_W:0]   LastCnt = (PRED_W+1)'(NODES - 1);
    localparam logic [PRED_W-1:0] OneIdx  = PRED_W'(1);
    localparam logic [PRED_W:0]   OneCnt  = (PRED_W+1)'(1);

    state_e              state_q, state_d;
    logic [PRED_W-1:0]   i_q, i_d, j_q, j_d, cur_q, cur_d, start_q, start_d;
    logic [PRED_W-1:0]   pred_q, pred_d;
    logic [PRED_W:0]     cnt_q, cnt_d, len_q, len_d;
    logic                found_q, found_d, lat_q, lat_d, last_q, last_d;

    logic [PRED_W-1:0]   pred_a, pred_now;
    logic                last_now, violation;
    logic signed [WEIGHT_W:0] sw_ext, e_ext, dw_ext, sum_ext;
    logic                unused_pred_b;

    assign pred_a        = vertmat_q_a[PRED_W+WEIGHT_W-1:WEIGHT_W];
    assign unused_pred_b = ^vertmat_q_b[PRED_W+WEIGHT_W-1:WEIGHT_W];

    // One extra bit so the relaxation sum cannot overflow.
    assign sw_ext  = {vertmat_q_a[WEIGHT_W-1], vertmat_q_a[WEIGHT_W-1:0]};
    assign dw_ext  = {vertmat_q_b[WEIGHT_W-1], vertmat_q_b[WEIGHT_W-1:0]};
    assign e_ext   = {adjmat_q[WEIGHT_W-1], adjmat_q};
    assign sum_ext = sw_ext + e_ext;
    assign violation = (adjmat_q != '0) && (vertmat_q_a[WEIGHT_W-1:0] != INF) &&
                       (sum_ext < dw_ext);

    assign out_vertex  = cur_q;
    assign cycle_found = found_q;
    assign cycle_len   = len_q;
    assign cycle_done  = (state_q == StDone);

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        cur_d   = cur_q;
        start_d = start_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        found_d = found_q;
        lat_d   = lat_q;
        pred_d  = pred_q;
        last_d  = last_q;

        vertmat_addr_a  = cur_q;
        vertmat_addr_b  = j_q;
        adjmat_row_addr = i_q;
        adjmat_col_addr = j_q;
        out_valid       = 1'b0;
        out_last        = 1'b0;

        // Memory data is only fresh in the first EMIT cycle; later cycles use the latched copy.
        pred_now = lat_q ? pred_q : pred_a;
        last_now = lat_q ? last_q : ((pred_a == start_q) || (len_q == LastCnt));

        case (state_q)
            StIdle: begin
                if (bellman_done) begin
                    i_d     = '0;
                    j_d     = '0;
                    state_d = StScanRd;
                end
            end
            StScanRd: begin
                vertmat_addr_a = i_q;
                state_d        = StScanChk;
            end
            StScanChk: begin
                vertmat_addr_a = i_q;
                if (violation) begin
                    found_d = 1'b1;
                    cur_d   = j_q;
                    cnt_d   = '0;
                    state_d = StWalkRd;
                end else if ((i_q == LastIdx) && (j_q == LastIdx)) begin
                    found_d = 1'b0;
                    state_d = StDone;
                end else begin
                    state_d = StScanRd;
                    if (j_q == LastIdx) begin
                        j_d = '0;
                        i_d = i_q + OneIdx;
                    end else begin
                        j_d = j_q + OneIdx;
                    end
                end
            end
            StWalkRd: state_d = StWalk;
            StWalk: begin
                // After NODES steps the walk is guaranteed to sit on the cycle.
                cur_d = pred_a;
                cnt_d = cnt_q + OneCnt;
                if (cnt_q == LastCnt) begin
                    start_d = pred_a;
                    len_d   = '0;
                    state_d = StEmitRd;
                end else begin
                    state_d = StWalkRd;
                end
            end
            StEmitRd: begin
                lat_d   = 1'b0;
                state_d = StEmit;
            end
            StEmit: begin
                out_valid = 1'b1;
                out_last  = last_now;
                lat_d     = 1'b1;
                pred_d    = pred_now;
                last_d    = last_now;
                if (out_ready) begin
                    len_d   = len_q + OneCnt;
                    cur_d   = pred_now;
                    lat_d   = 1'b0;
                    state_d = last_now ? StDone : StEmitRd;
                end
            end
            StDone:  state_d = StDone;
            default: state_d = StDone;
        endcase
    end

    always_ff @(posedge clk) begin
        if (cycle_reset) begin
            state_q <= StIdle;
            i_q     <= '0;
            j_q     <= '0;
            cur_q   <= '0;
            start_q <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
            found_q <= 1'b0;
            lat_q   <= 1'b0;
            pred_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            cur_q   <= cur_d;
            start_q <= start_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            found_q <= found_d;
            lat_q   <= lat_d;
            pred_q  <= pred_d;
            last_q  <= last_d;
        end
    end

endmodule

// File: tb/tb_arb_cycle_extract.sv
// Scoreboard bench for arb_cycle_extract: directed graphs from the test plan plus random graphs,
// expected beats produced by a behavioural model of the scan / walk / emit rules.
module tb_arb_cycle_extract;

    localparam int N  = 4;
    localparam int PW = 8;
    localparam int WW = 32;
    localparam int AW = 2;
    localparam logic [WW-1:0] INFV = 32'h7FFF_FFFF;
    localparam logic [PW-1:0] NV   = 8'd4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              cycle_reset, bellman_done, out_ready;
    logic [PW+WW-1:0]  vertmat_q_a, vertmat_q_b;
    logic [WW-1:0]     adjmat_q;
    logic [PW-1:0]     vertmat_addr_a, vertmat_addr_b, adjmat_row_addr, adjmat_col_addr;
    logic [PW-1:0]     out_vertex;
    logic              out_valid, out_last, cycle_found, cycle_done;
    logic [PW:0]       cycle_len;

    arb_cycle_extract #(.NODES(N), .PRED_W(PW), .WEIGHT_W(WW), .INF(INFV)) dut (
        .clk             (clk),
        .cycle_reset     (cycle_reset),
        .bellman_done    (bellman_done),
        .vertmat_q_a     (vertmat_q_a),
        .vertmat_q_b     (vertmat_q_b),
        .adjmat_q        (adjmat_q),
        .vertmat_addr_a  (vertmat_addr_a),
        .vertmat_addr_b  (vertmat_addr_b),
        .adjmat_row_addr (adjmat_row_addr),
        .adjmat_col_addr (adjmat_col_addr),
        .out_vertex      (out_vertex),
        .out_valid       (out_valid),
        .out_last        (out_last),
        .out_ready       (out_ready),
        .cycle_found     (cycle_found),
        .cycle_len       (cycle_len),
        .cycle_done      (cycle_done)
    );

    logic [PW-1:0] m_pred [N];
    logic [WW-1:0] m_w    [N];
    logic [WW-1:0] m_adj  [N][N];

    // Synchronous-read memories.
    always @(posedge clk) begin
        vertmat_q_a <= (vertmat_addr_a < NV) ?
            {m_pred[vertmat_addr_a[AW-1:0]], m_w[vertmat_addr_a[AW-1:0]]} : '0;
        vertmat_q_b <= (vertmat_addr_b < NV) ?
            {m_pred[vertmat_addr_b[AW-1:0]], m_w[vertmat_addr_b[AW-1:0]]} : '0;
        adjmat_q <= (adjmat_row_addr < NV && adjmat_col_addr < NV) ?
            m_adj[adjmat_row_addr[AW-1:0]][adjmat_col_addr[AW-1:0]] : '0;
    end

    int checks = 0;
    int passes = 0;
    int hs_count = 0;
    int ready_mode = 0;
    logic [PW:0] exp_q [$];

    task automatic check(input string name, input longint act, input longint want);
        checks++;
        if (act == want) passes++;
        else $display("FAIL %s: got %0d, want %0d", name, act, want);
    endtask

    // Ready driver: 0 always ready, 1 random, 2 stall 5 cycles per beat, 3 never ready.
    initial begin
        int stall_cnt;
        stall_cnt = 0;
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: out_ready = 1'b1;
                1: out_ready = ($urandom_range(0, 1) == 1);
                2: begin
                    if (out_valid && stall_cnt < 5) begin
                        out_ready = 1'b0;
                        stall_cnt++;
                    end else if (out_valid) begin
                        out_ready = 1'b1;
                        stall_cnt = 0;
                    end else begin
                        out_ready = 1'b0;
                    end
                end
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Monitor: pops the scoreboard on every handshake and checks stalled beats hold still.
    initial begin
        bit          stall_pend;
        logic [PW:0] stall_beat;
        logic [PW:0] want;
        stall_pend = 1'b0;
        stall_beat = '0;
        forever begin
            @(negedge clk);
            if (out_valid) begin
                if (stall_pend) check("stall_stable", {out_last, out_vertex}, stall_beat);
                if (out_ready) begin
                    hs_count++;
                    stall_pend = 1'b0;
                    if (exp_q.size() == 0) begin
                        checks++;
                        $display("FAIL unexpected_beat: got vertex %0d last %0d, want no beat",
                                 out_vertex, out_last);
                    end else begin
                        want = exp_q.pop_front();
                        check("beat", {out_last, out_vertex}, want);
                    end
                end else begin
                    stall_pend = 1'b1;
                    stall_beat = {out_last, out_vertex};
                end
            end else begin
                stall_pend = 1'b0;
            end
        end
    end

    // Reference: first violating edge in row-major order, NODES predecessor hops, then the loop.
    task automatic model_push(output bit found, output int nb);
        longint sw, e, dw;
        int cur, v, nxt, start;
        bit last;
        logic [PW-1:0] vb;
        found = 1'b0;
        nb = 0;
        cur = 0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                sw = longint'($signed(m_w[i]));
                e  = longint'($signed(m_adj[i][j]));
                dw = longint'($signed(m_w[j]));
                if (!found && m_adj[i][j] != 0 && m_w[i] != INFV && sw + e < dw) begin
                    found = 1'b1;
                    cur = j;
                end
            end
        end
        if (found) begin
            repeat (N) cur = int'(m_pred[cur]);
            start = cur;
            v = start;
            for (int k = 0; k < N; k++) begin
                nxt  = int'(m_pred[v]);
                last = (nxt == start) || (k == N - 1);
                vb   = PW'(v);
                exp_q.push_back({last, vb});
                nb++;
                if (last) break;
                v = nxt;
            end
        end
    endtask

    task automatic load_clear();
        for (int v = 0; v < N; v++) begin
            m_pred[v] = '0;
            m_w[v] = '0;
            for (int j = 0; j < N; j++) m_adj[v][j] = '0;
        end
    endtask

    task automatic load_triangle();
        load_clear();
        m_adj[1][2] = WW'(-3);
        m_adj[2][3] = WW'(1);
        m_adj[3][1] = WW'(1);
        m_pred[2] = 8'd1;
        m_pred[3] = 8'd2;
        m_pred[1] = 8'd3;
        m_w[1] = WW'(-2);
        m_w[2] = WW'(-5);
        m_w[3] = WW'(-4);
    endtask

    task automatic load_random();
        int r;
        for (int v = 0; v < N; v++) begin
            m_pred[v] = PW'($urandom_range(0, N - 1));
            m_w[v] = ($urandom_range(0, 4) == 0) ? INFV : WW'(int'($urandom_range(0, 40)) - 20);
            for (int j = 0; j < N; j++) begin
                r = int'($urandom_range(0, 19));
                m_adj[v][j] = ($urandom_range(0, 9) < 4) ? WW'((r < 10) ? r - 10 : r - 9) : '0;
            end
        end
    endtask

    task automatic run_scenario(input string tag, input int rmode, input bit do_reset);
        bit found;
        int nb;
        int cyc;
        exp_q.delete();
        hs_count = 0;
        ready_mode = rmode;
        if (do_reset) begin
            cycle_reset = 1'b1;
            bellman_done = 1'b0;
            repeat (2) begin @(posedge clk); #1; end
            cycle_reset = 1'b0;
            check({tag, "/rst_valid"}, out_valid, 0);
            check({tag, "/rst_found"}, cycle_found, 0);
            check({tag, "/rst_len"}, cycle_len, 0);
            check({tag, "/rst_done"}, cycle_done, 0);
        end
        model_push(found, nb);
        bellman_done = 1'b1;
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
        end while (!cycle_done && cyc < 1000);
        check({tag, "/done_seen"}, cycle_done, 1);
        if (!found) check({tag, "/scan_cycles"}, cyc - 1, 2 * N * N);
        repeat (3) begin @(posedge clk); #1; end
        check({tag, "/done_hold"}, cycle_done, 1);
        check({tag, "/found"}, cycle_found, found);
        check({tag, "/len"}, cycle_len, nb);
        check({tag, "/handshakes"}, hs_count, nb);
        check({tag, "/leftover"}, exp_q.size(), 0);
        bellman_done = 1'b0;
    endtask

    task automatic reset_mid_emit();
        int cyc;
        load_triangle();
        run_scenario("pre_abort", 0, 1'b1);
        exp_q.delete();
        ready_mode = 3;
        cycle_reset = 1'b1;
        @(posedge clk);
        #1;
        cycle_reset = 1'b0;
        bellman_done = 1'b1;
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
        end while (!out_valid && cyc < 500);
        check("abort/valid_seen", out_valid, 1);
        cycle_reset = 1'b1;
        bellman_done = 1'b0;
        @(posedge clk);
        #1;
        check("abort/valid", out_valid, 0);
        check("abort/found", cycle_found, 0);
        check("abort/len", cycle_len, 0);
        check("abort/done", cycle_done, 0);
        cycle_reset = 1'b0;
        @(posedge clk);
        #1;
        check("abort/idle_valid", out_valid, 0);
        check("abort/idle_done", cycle_done, 0);
        run_scenario("abort_rerun", 0, 1'b0);
    endtask

    initial begin
        cycle_reset = 1'b1;
        bellman_done = 1'b0;
        load_clear();
        @(posedge clk);
        #1;

        load_clear();
        m_w[1] = WW'(5);
        m_w[2] = WW'(8);
        m_w[3] = INFV;
        m_pred[2] = 8'd1;
        m_adj[0][1] = WW'(5);
        m_adj[1][2] = WW'(3);
        run_scenario("chain", 1, 1'b1);

        load_triangle();
        run_scenario("triangle", 0, 1'b1);

        load_triangle();
        run_scenario("triangle_stall", 2, 1'b1);

        load_clear();
        m_adj[2][2] = WW'(-1);
        m_pred[2] = 8'd2;
        run_scenario("self_loop", 0, 1'b1);

        load_clear();
        m_w[3] = INFV;
        m_adj[3][0] = WW'(-10);
        run_scenario("inf_src", 0, 1'b1);

        reset_mid_emit();

        for (int t = 0; t < 20; t++) begin
            load_random();
            run_scenario($sformatf("rand%0d", t), int'($urandom_range(0, 2)), 1'b1);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
